// File: rtl/lms_spi_arbiter_if.sv
// lms_spi_arbiter_if: memory-mapped bus to the SPI core.
//   spi_select     master -> core  access strobe (chip select of the core)
//   mem_addr       master -> core  register address
//   data_from_cpu  master -> core  write data
//   write_n        master -> core  active-low write strobe
//   read_n         master -> core  active-low read strobe
//   data_to_cpu    core -> master  read data
interface lms_spi_arbiter_if;
    logic        spi_select;
    logic [2:0]  mem_addr;
    logic [15:0] data_from_cpu;
    logic        write_n;
    logic        read_n;
    logic [15:0] data_to_cpu;

    modport master (
        output spi_select, mem_addr, data_from_cpu, write_n, read_n,
        input  data_to_cpu
    );

    modport slave (
        input  spi_select, mem_addr, data_from_cpu, write_n, read_n,
        output data_to_cpu
    );
endinterface

// File: rtl/lms_spi_arbiter.sv
// lms_spi_arbiter: round-robin arbiter that lets two requesters share one SPI
// core. Each granted transaction selects the slave, asserts SSO, moves NBYTES
// bytes (MSB first, MISO shifted into rdata), waits for the shifter to empty
// and releases SSO. Every status poll is bounded by POLL_TIMEOUT.
//   clk, reset            clock; synchronous active-high reset
//   req[1:0]              per-requester request, held until done
//   req_word0/1           transmit frames
//   req_ss0/1             one-hot slave-select patterns
//   done[1:0], err[1:0]   one-cycle completion / timeout pulses
//   rdata                 received frame, valid while any done bit is high
//   busy                  high from grant until done
//   spi                   master side of the SPI-core register bus
module lms_spi_arbiter #(
    parameter int unsigned NBYTES       = 4,
    parameter int unsigned POLL_TIMEOUT = 4095
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req,
    input  logic [8*NBYTES-1:0]   req_word0,
    input  logic [8*NBYTES-1:0]   req_word1,
    input  logic [1:0]            req_ss0,
    input  logic [1:0]            req_ss1,
    output logic [1:0]            done,
    output logic [1:0]            err,
    output logic [8*NBYTES-1:0]   rdata,
    output logic                  busy,
    lms_spi_arbiter_if.master     spi
);
    localparam int unsigned FrameW = 8 * NBYTES;
    localparam int unsigned CntW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned PollW  = $clog2(POLL_TIMEOUT + 1);
    localparam logic [CntW-1:0]  LastByte = CntW'(NBYTES - 1);
    localparam logic [PollW-1:0] PollLast = PollW'(POLL_TIMEOUT - 1);

    typedef enum logic [3:0] {
        StIdle, StSel, StSsoOn, StPollT, StWr, StPollR, StRd, StPollTmt, StSsoOff, StDone
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          phase_q, phase_d;     // 0,1 active, 2 idle
    logic [CntW-1:0]     byte_cnt_q, byte_cnt_d;
    logic [PollW-1:0]    poll_cnt_q, poll_cnt_d;
    logic                err_flag_q, err_flag_d;
    logic [FrameW-1:0]   rdata_q, rdata_d;
    logic [FrameW-1:0]   tx_q, tx_d;
    logic [2:0]          stat_q, stat_d;       // {RRDY, TRDY, TMT}
    logic [1:0]          ss_q, ss_d;
    logic                gnt_q, gnt_d;
    logic                last_q, last_d;

    logic                is_access, step, acc_wr, win;
    logic [2:0]          acc_addr;
    logic [15:0]         acc_data;
    logic [31:0]         pad_bits;
    logic                unused_rx_hi;

    assign is_access    = (state_q != StIdle) && (state_q != StDone);
    assign step         = is_access && (phase_q == 2'd2);
    // Left-align a frame cut short by a timeout; bytes never received become 0.
    assign pad_bits     = 32'(FrameW) - 32'(byte_cnt_q) * 32'd8;
    assign unused_rx_hi = ^spi.data_to_cpu[15:8];
    assign rdata        = rdata_q;
    assign busy         = (state_q != StIdle);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        byte_cnt_d = byte_cnt_q;
        poll_cnt_d = poll_cnt_q;
        err_flag_d = err_flag_q;
        rdata_d    = rdata_q;
        tx_d       = tx_q;
        stat_d     = stat_q;
        ss_d       = ss_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        acc_wr     = 1'b0;
        acc_addr   = 3'd0;
        acc_data   = 16'h0000;
        win        = 1'b0;
        done       = 2'b00;
        err        = 2'b00;
        spi.spi_select    = 1'b0;
        spi.mem_addr      = 3'd0;
        spi.data_from_cpu = 16'h0000;
        spi.write_n       = 1'b1;
        spi.read_n        = 1'b1;

        // Every completed access starts the next poll sequence from zero.
        if (step) poll_cnt_d = '0;

        case (state_q)
            StIdle: begin
                err_flag_d = 1'b0;
                if (req != 2'b00) begin
                    // On a tie the requester not granted last time wins.
                    win        = (req == 2'b11) ? ~last_q : req[1];
                    gnt_d      = win;
                    last_d     = win;
                    tx_d       = win ? req_word1 : req_word0;
                    ss_d       = win ? req_ss1 : req_ss0;
                    byte_cnt_d = '0;
                    poll_cnt_d = '0;
                    phase_d    = 2'd0;
                    state_d    = StSel;
                end
            end
            StSel: begin
                acc_wr   = 1'b1;
                acc_addr = 3'd5;
                acc_data = {14'b0, ss_q};
                if (step) state_d = StSsoOn;
            end
            StSsoOn: begin
                acc_wr   = 1'b1;
                acc_addr = 3'd3;
                acc_data = 16'h0400;
                if (step) state_d = StPollT;
            end
            StPollT: begin
                acc_addr = 3'd2;
                if (step) begin
                    if (stat_q[1]) begin
                        state_d = StWr;
                    end else if (poll_cnt_q == PollLast) begin
                        state_d    = StSsoOff;
                        err_flag_d = 1'b1;
                        rdata_d    = rdata_q << pad_bits;
                    end else begin
                        poll_cnt_d = poll_cnt_q + PollW'(1);
                    end
                end
            end
            StWr: begin
                acc_wr   = 1'b1;
                acc_addr = 3'd1;
                acc_data = {8'h00, tx_q[FrameW-1 -: 8]};
                if (step) begin
                    tx_d    = tx_q << 8;
                    state_d = StPollR;
                end
            end
            StPollR: begin
                acc_addr = 3'd2;
                if (step) begin
                    if (stat_q[2]) begin
                        state_d = StRd;
                    end else if (poll_cnt_q == PollLast) begin
                        state_d    = StSsoOff;
                        err_flag_d = 1'b1;
                        rdata_d    = rdata_q << pad_bits;
                    end else begin
                        poll_cnt_d = poll_cnt_q + PollW'(1);
                    end
                end
            end
            StRd: begin
                acc_addr = 3'd0;
                if (step) begin
                    if (byte_cnt_q == LastByte) begin
                        state_d = StPollTmt;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CntW'(1);
                        state_d    = StPollT;
                    end
                end
            end
            StPollTmt: begin
                acc_addr = 3'd2;
                if (step) begin
                    if (stat_q[0]) begin
                        state_d = StSsoOff;
                    end else if (poll_cnt_q == PollLast) begin
                        state_d    = StSsoOff;
                        err_flag_d = 1'b1;
                    end else begin
                        poll_cnt_d = poll_cnt_q + PollW'(1);
                    end
                end
            end
            StSsoOff: begin
                acc_wr   = 1'b1;
                acc_addr = 3'd3;
                acc_data = 16'h0000;
                if (step) state_d = StDone;
            end
            StDone: begin
                done    = gnt_q ? 2'b10 : 2'b01;
                err     = err_flag_q ? done : 2'b00;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (is_access && (phase_q != 2'd2)) begin
            spi.spi_select    = 1'b1;
            spi.mem_addr      = acc_addr;
            spi.data_from_cpu = acc_data;
            spi.write_n       = ~acc_wr;
            spi.read_n        = acc_wr;
            // Read data is taken on the edge closing the second active cycle.
            if (phase_q == 2'd1) begin
                stat_d = spi.data_to_cpu[7:5];
                if (state_q == StRd) begin
                    if (byte_cnt_q == '0) begin
                        rdata_d = FrameW'(spi.data_to_cpu[7:0]);
                    end else begin
                        rdata_d = (rdata_q << 8) | FrameW'(spi.data_to_cpu[7:0]);
                    end
                end
            end
        end
        if (is_access) phase_d = step ? 2'd0 : phase_q + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            phase_q    <= 2'd0;
            byte_cnt_q <= '0;
            poll_cnt_q <= '0;
            err_flag_q <= 1'b0;
            rdata_q    <= '0;
            tx_q       <= '0;
            stat_q     <= 3'b000;
            ss_q       <= 2'b00;
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;  // pretend requester 1 went last so 0 wins the first tie
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            byte_cnt_q <= byte_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            err_flag_q <= err_flag_d;
            rdata_q    <= rdata_d;
            tx_q       <= tx_d;
            stat_q     <= stat_d;
            ss_q       <= ss_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
        end
    end
endmodule

// File: tb/tb_lms_spi_arbiter.sv
// Directed bench for lms_spi_arbiter with an SPI-core model (MISO loopback).
module tb_lms_spi_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [31:0] req_word0, req_word1;
    logic [1:0]  req_ss0, req_ss1;
    logic [1:0]  done, err;
    logic [31:0] rdata;
    logic        busy;

    lms_spi_arbiter_if bus ();

    lms_spi_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_word0 (req_word0),
        .req_word1 (req_word1),
        .req_ss0   (req_ss0),
        .req_ss1   (req_ss1),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .busy      (busy),
        .spi       (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Core model state, all owned by the negedge monitor.
    logic        trdy_en;
    logic        rx_full;
    int          rrdy_delay;
    logic [7:0]  rx_byte;
    int          n_stat, n_rx;
    logic [2:0]  wr_a[$];
    logic [15:0] wr_d[$];
    int          run_len;
    logic        unstable, both_low;
    logic [2:0]  cur_addr;
    logic [15:0] cur_data;
    logic        cur_wn;
    logic        act_now;

    always_comb begin
        bus.data_to_cpu = 16'h0000;
        if (bus.mem_addr == 3'd2) begin
            bus.data_to_cpu = {8'h00, rx_full && (rrdy_delay == 0), trdy_en && !rx_full,
                               !rx_full, 5'b00000};
        end else if (bus.mem_addr == 3'd0) begin
            bus.data_to_cpu = {8'h00, rx_byte};
        end
    end

    always @(negedge clk) begin
        act_now = bus.spi_select && (!bus.write_n || !bus.read_n);
        if (reset) begin
            run_len = 0; unstable = 1'b0; both_low = 1'b0;
            rx_full = 1'b0; rrdy_delay = 0; rx_byte = 8'h00;
        end else if (act_now) begin
            if (!bus.write_n && !bus.read_n) both_low = 1'b1;
            if (run_len != 0 && (bus.mem_addr !== cur_addr || bus.data_from_cpu !== cur_data ||
                                 bus.write_n !== cur_wn)) unstable = 1'b1;
            cur_addr = bus.mem_addr;
            cur_data = bus.data_from_cpu;
            cur_wn   = bus.write_n;
            run_len++;
        end else begin
            if (run_len != 0) begin
                checks++;
                assert (run_len == 2 && !unstable && !both_low && !bus.spi_select &&
                        bus.write_n && bus.read_n)
                else begin
                    errors++;
                    $error("FAIL bus_timing: observed len=%0d unstable=%0b both_low=%0b sel=%0b wn=%0b rn=%0b required len=2 stable idle",
                           run_len, unstable, both_low, bus.spi_select, bus.write_n, bus.read_n);
                end
                if (!cur_wn) begin
                    wr_a.push_back(cur_addr);
                    wr_d.push_back(cur_data);
                    if (cur_addr == 3'd1) begin
                        rx_byte = cur_data[7:0]; rx_full = 1'b1; rrdy_delay = 2;
                    end
                end else if (cur_addr == 3'd2) begin
                    n_stat++;
                    if (rx_full && rrdy_delay != 0) rrdy_delay--;
                end else if (cur_addr == 3'd0) begin
                    n_rx++;
                    rx_full = 1'b0;
                end
            end
            run_len = 0; unstable = 1'b0; both_low = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sel"},   {31'b0, bus.spi_select}, 32'd0);
        chk({tag, "_wn"},    {31'b0, bus.write_n}, 32'd1);
        chk({tag, "_rn"},    {31'b0, bus.read_n}, 32'd1);
        chk({tag, "_addr"},  {29'b0, bus.mem_addr}, 32'd0);
        chk({tag, "_wdata"}, {16'b0, bus.data_from_cpu}, 32'd0);
        chk({tag, "_done"},  {30'b0, done}, 32'd0);
        chk({tag, "_err"},   {30'b0, err}, 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_busy"},  {31'b0, busy}, 32'd0);
    endtask

    task automatic wait_done(input string tag, input int budget, output logic [1:0] d,
                             output logic [1:0] e, output logic [31:0] r);
        logic seen;
        seen = 1'b0; d = 2'b00; e = 2'b00; r = 32'h0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done != 2'b00) begin
                seen = 1'b1; d = done; e = err; r = rdata;
                break;
            end
        end
        chk({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1; req = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    function automatic int count_sso_off(input int from);
        int n = 0;
        for (int i = from; i < wr_a.size(); i++)
            if (wr_a[i] == 3'd3 && wr_d[i] == 16'h0000) n++;
        return n;
    endfunction

    logic [1:0]  d, e;
    logic [31:0] r;
    int          base_w, base_s, base_rx;
    logic        reached;
    logic [2:0]  exp_a [7];
    logic [15:0] exp_d [7];
    logic [1:0]  exp_g [4];
    logic [31:0] exp_w [4];

    initial begin
        exp_a = '{3'd5, 3'd3, 3'd1, 3'd1, 3'd1, 3'd1, 3'd3};
        exp_d = '{16'h0001, 16'h0400, 16'h0081, 16'h0023, 16'h00AB, 16'h00CD, 16'h0000};
        trdy_en = 1'b1;
        req_word0 = 32'h0; req_word1 = 32'h0; req_ss0 = 2'b00; req_ss1 = 2'b00;

        // Reset values
        reset = 1'b1; req = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        // Single request with loopback; inputs changed after grant must not matter
        base_w = wr_a.size();
        req_word0 = 32'h8123_ABCD; req_ss0 = 2'b01; req = 2'b01;
        @(posedge clk); #1;
        chk("single_busy", {31'b0, busy}, 32'd1);
        req_word0 = 32'hDEAD_BEEF; req_ss0 = 2'b10;
        wait_done("single", 3000, d, e, r);
        req = 2'b00;
        chk("single_done", {30'b0, d}, 32'h1);
        chk("single_err", {30'b0, e}, 32'h0);
        chk("single_rdata", r, 32'h8123_ABCD);
        chk("single_nwrites", wr_a.size() - base_w, 32'd7);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("single_wr%0d_addr", i), {29'b0, wr_a[base_w + i]}, {29'b0, exp_a[i]});
            chk($sformatf("single_wr%0d_data", i), {16'b0, wr_d[base_w + i]}, {16'b0, exp_d[i]});
        end
        @(posedge clk); #1;
        chk("single_done_pulse", {30'b0, done}, 32'd0);
        chk("single_busy_after", {31'b0, busy}, 32'd0);
        chk("single_rdata_hold", rdata, 32'h8123_ABCD);

        // Simultaneous requests from reset, held: grants alternate 0,1,0,1
        do_reset();
        req_word0 = 32'hA5A5_0001; req_ss0 = 2'b01;
        req_word1 = 32'h1234_5678; req_ss1 = 2'b10;
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_w = '{32'hA5A5_0001, 32'h1234_5678, 32'hA5A5_0001, 32'h1234_5678};
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            base_w = wr_a.size();
            wait_done($sformatf("rr%0d", k), 3000, d, e, r);
            chk($sformatf("rr%0d_grant", k), {30'b0, d}, {30'b0, exp_g[k]});
            chk($sformatf("rr%0d_rdata", k), r, exp_w[k]);
            chk($sformatf("rr%0d_ss", k), {16'b0, wr_d[base_w]}, {30'b0, exp_g[k]});
        end
        req = 2'b00;

        // TRDY never set: POLL_TIMEOUT status reads then SSO release
        @(posedge clk); #1;
        trdy_en = 1'b0;
        base_w = wr_a.size(); base_s = n_stat;
        req_word0 = 32'h5555_AAAA; req_ss0 = 2'b01; req = 2'b01;
        wait_done("tmo", 20000, d, e, r);
        req = 2'b00;
        chk("tmo_done", {30'b0, d}, 32'h1);
        chk("tmo_err", {30'b0, e}, 32'h1);
        chk("tmo_rdata", r, 32'h0);
        chk("tmo_polls", n_stat - base_s, 32'd4095);
        chk("tmo_nwrites", wr_a.size() - base_w, 32'd3);
        chk("tmo_last_addr", {29'b0, wr_a[wr_a.size() - 1]}, 32'd3);
        chk("tmo_last_data", {16'b0, wr_d[wr_d.size() - 1]}, 32'h0);
        @(posedge clk); #1;
        chk("tmo_err_pulse", {30'b0, err}, 32'd0);
        trdy_en = 1'b1;

        // Reset during byte 2 aborts at once without releasing SSO
        base_w = wr_a.size(); base_rx = n_rx;
        req_word0 = 32'h1357_9BDF; req_ss0 = 2'b01; req = 2'b01;
        reached = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (n_rx - base_rx >= 2) begin reached = 1'b1; break; end
        end
        chk("rst_reached_byte2", {31'b0, reached}, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; req = 2'b00;
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        reset = 1'b0;
        chk("midrst_no_sso_off", count_sso_off(base_w), 32'd0);
        @(posedge clk); #1;
        chk("midrst_idle", {31'b0, bus.spi_select}, 32'd0);

        // New request from requester 1; dropping req mid-flight is ignored
        base_w = wr_a.size();
        req_word1 = 32'hCAFE_F00D; req_ss1 = 2'b10; req = 2'b10;
        @(posedge clk); #1;
        req = 2'b00;
        wait_done("post", 3000, d, e, r);
        chk("post_done", {30'b0, d}, 32'h2);
        chk("post_err", {30'b0, e}, 32'h0);
        chk("post_rdata", r, 32'hCAFE_F00D);
        chk("post_ss", {16'b0, wr_d[base_w]}, 32'h0002);
        chk("post_sso_off", count_sso_off(base_w), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lms_spi_arbiter.md
LMS_SPI_ARBITER -- requirements
Module: lms_spi_arbiter

Interface
REQ-001 Parameter: NBYTES, 4, bytes per transaction (LMS frame: 1 R/W bit + 15-bit address + 16-bit data).
REQ-002 Parameter: POLL_TIMEOUT, 4095, maximum status polls per wait before abort.
REQ-003 Port: clk  in  1  system clock; all logic is on its rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
REQ-005 Port: req[1:0]  in  2  per-requester transaction request; held high until done.
REQ-006 Port: req_word0 / req_word1  in  32 each  transmit frame, sent MSB byte first.
REQ-007 Port: req_ss0 / req_ss1  in  2 each  one-hot slave-select pattern.
REQ-008 Port: done[1:0]  out  2  one-cycle pulse, transaction finished for that requester.
REQ-009 Port: err[1:0]  out  2  one-cycle pulse with done, poll timeout occurred.
REQ-010 Port: rdata  out  32  received frame; valid when any done bit is high.
REQ-011 Port: busy  out  1  high from grant until done.
REQ-012 SPI-core master ports: spi_select out 1; mem_addr out 3; data_from_cpu out 16; write_n out 1; read_n out 1; data_to_cpu in 16.

Function
REQ-013 Bus access SHALL assert spi_select with write_n or read_n low for exactly 2 cycles, with mem_addr and data stable, and then SHALL leave 1 idle cycle with spi_select=0, write_n=1, read_n=1.
REQ-014 Read data SHALL be captured from data_to_cpu on the edge that ends the second access cycle.
REQ-015 Core registers used: addr0 rx data; addr1 tx data; addr2 status (bit5 TMT, bit6 TRDY, bit7 RRDY); addr3 control (bit10 SSO); addr5 slave-enable.
REQ-016 Arbitration SHALL happen in IDLE only and SHALL be round-robin: the requester not most recently granted wins a tie; the pointer resets to requester 0 winning the first tie.
REQ-017 States SHALL be: IDLE -> SEL (write addr5 = {14'b0, ss}) -> SSO_ON (write addr3 = 0x0400) -> per byte [POLL_T (read addr2 until bit6) -> WR (write addr1 = byte) -> POLL_R (read addr2 until bit7) -> RD (read addr0, shift byte into rdata LSB)] -> POLL_TMT (read addr2 until bit5) -> SSO_OFF (write addr3 = 0x0000) -> DONE -> IDLE.
REQ-018 The byte counter SHALL count 0..NBYTES-1; after RD of the last byte it SHALL go to POLL_TMT, otherwise to POLL_T.
REQ-019 Each POLL state SHALL count polls; on the POLL_TIMEOUT-th unsatisfied poll it SHALL jump to SSO_OFF with the error flag set, so SSO is always released.
REQ-020 DONE SHALL pulse done[g] for 1 cycle, and err[g] if the error flag is set; the flag SHALL clear in IDLE.
REQ-021 rdata SHALL hold the last received frame until the next transaction's first RD; after a timeout, bytes not yet received SHALL read as 0.
REQ-022 Deassertion of req[g] mid-transaction SHALL be ignored; the sequence SHALL complete.
REQ-023 Request words and slave pattern SHALL be latched at grant; later input changes SHALL have no effect.
REQ-024 The next arbitration SHALL occur no earlier than the cycle after DONE.

Reset
REQ-025 On reset: state IDLE, spi_select=0, write_n=1, read_n=1, mem_addr=0, data_from_cpu=0, done=0, err=0, rdata=0, busy=0, RR pointer favours requester 0.
REQ-026 Reset mid-transaction SHALL abort immediately without a SSO_OFF write; after reset the core also needs resetting.

Verification
REQ-027 Single request: req0=1, word=0x8123_ABCD, ss=01, with an SPI core model and MISO loopback -> bus writes in order addr5=0x0001, addr3=0x0400, addr1 bytes 0x81, 0x23, 0xAB, 0xCD, addr3=0x0000; done[0] pulses with rdata=0x8123ABCD and err=0.
REQ-028 Simultaneous req=11 from reset -> requester 0 is served first, then requester 1; with both held continuously, grants alternate 0,1,0,1.
REQ-029 Status model never sets TRDY -> exactly POLL_TIMEOUT addr2 reads, then an addr3=0x0000 write; done and err pulse together; rdata=0.
REQ-030 Bus timing check: every access is 2 cycles active plus 1 idle cycle, and read_n and write_n are never low together.
REQ-031 Reset asserted during byte 2 -> next cycle all outputs are at reset values; a new req1 afterwards is granted and completes normally.
